// File: rtl/timer_unit_pkg.sv
// Shared constants for the 8051 timer block: SFR addresses, TCON bit positions,
// timer mode encoding and the per-mode increment helper.
package timer_unit_pkg;

  localparam logic [7:0] SFR_TCON = 8'h88;
  localparam logic [7:0] SFR_TMOD = 8'h89;
  localparam logic [7:0] SFR_TL0  = 8'h8A;
  localparam logic [7:0] SFR_TL1  = 8'h8B;
  localparam logic [7:0] SFR_TH0  = 8'h8C;
  localparam logic [7:0] SFR_TH1  = 8'h8D;

  localparam int TCON_IT0 = 0;
  localparam int TCON_IE0 = 1;
  localparam int TCON_IT1 = 2;
  localparam int TCON_IE1 = 3;
  localparam int TCON_TR0 = 4;
  localparam int TCON_TF0 = 5;
  localparam int TCON_TR1 = 6;
  localparam int TCON_TF1 = 7;

  typedef enum logic [1:0] {
    MODE_13BIT  = 2'd0,
    MODE_16BIT  = 2'd1,
    MODE_RELOAD = 2'd2,
    MODE_SPLIT  = 2'd3
  } tmr_mode_e;

  typedef struct packed {
    logic      gate;
    logic      ct;
    tmr_mode_e mode;
  } tmod_nib_t;

  // Returns {overflow, th_next, tl_next} for one count event; split mode advances TL only.
  function automatic logic [16:0] tmr_inc(input tmr_mode_e mode, input logic [7:0] tl,
                                          input logic [7:0] th);
    logic [12:0] c13;
    logic [15:0] c16;
    c13 = {th, tl[4:0]} + 13'd1;
    c16 = {th, tl} + 16'd1;
    case (mode)
      MODE_13BIT:  tmr_inc = {(&{th, tl[4:0]}), c13[12:5], tl[7:5], c13[4:0]};
      MODE_16BIT:  tmr_inc = {(&{th, tl}), c16};
      MODE_RELOAD: tmr_inc = (&tl) ? {1'b1, th, th} : {1'b0, th, tl + 8'd1};
      default:     tmr_inc = {(&tl), th, tl + 8'd1};
    endcase
  endfunction

endpackage

// File: rtl/timer_unit_if.sv
// SFR bus between the CPU core and the timer block: write strobe/address/data
// out of the CPU, current register values back for the SFR read mux.
interface timer_unit_if;
  logic       sfr_wr;
  logic [7:0] sfr_addr;
  logic [7:0] sfr_wdata;
  logic [7:0] tmod;
  logic [7:0] tcon;
  logic [7:0] tl0;
  logic [7:0] th0;
  logic [7:0] tl1;
  logic [7:0] th1;

  modport master (output sfr_wr, sfr_addr, sfr_wdata,
                  input  tmod, tcon, tl0, th0, tl1, th1);
  modport slave  (input  sfr_wr, sfr_addr, sfr_wdata,
                  output tmod, tcon, tl0, th0, tl1, th1);
endinterface

// File: rtl/timer_unit_pin_edge_detect.sv
// Synchronizes one asynchronous pin and emits a registered one-clk pulse on each
// synchronized falling edge. Reset parks the chain at the idle-high pin level.
module timer_unit_pin_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   fall_q, fall_d;

  // Next-state for the synchronizer chain and edge pulse
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    dly_d  = sync_q[SYNC_STAGES-1];
    fall_d = dly_q & ~sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b1}};
      dly_q  <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = fall_q;

endmodule

// File: rtl/timer_unit.sv
// 8051 Timer0/Timer1 with TMOD/TCON/TLx/THx SFRs and INT0/INT1 flag logic.
// All SFR updates are arbitrated here between CPU writes, counting and interrupt acks.
module timer_unit
  import timer_unit_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  timer_unit_if.slave   bus,
  input  logic          t0_pin,
  input  logic          t1_pin,
  input  logic          int0_n,
  input  logic          int1_n,
  input  logic          ack_tf0,
  input  logic          ack_tf1,
  input  logic          ack_ie0,
  input  logic          ack_ie1,
  output logic          t1_ovf
);

  logic [7:0] tmod_q, tmod_d, tcon_q, tcon_d;
  logic [7:0] tl0_q, tl0_d, th0_q, th0_d, tl1_q, tl1_d, th1_q, th1_d;
  logic       t1_ovf_q, t1_ovf_d;
  logic       pend0_q, pend0_d, pend1_q, pend1_d;

  logic t0_lvl, t0_fall, t1_lvl, t1_fall;
  logic int0_lvl, int0_fall, int1_lvl, int1_fall;

  tmod_nib_t  cfg0, cfg1;
  logic       wr_tmod, wr_tcon, wr_tl0, wr_th0, wr_tl1, wr_th1;
  logic       run0, run1, ev0, ev1, ev_h0;
  logic       ovf0, ovf1, ovf_h0, tf1_set;
  logic [16:0] inc0, inc1;

  timer_unit_pin_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_t0 (
    .clk(clk), .rst_n(rst_n), .pin(t0_pin), .level(t0_lvl), .fall(t0_fall));
  timer_unit_pin_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_t1 (
    .clk(clk), .rst_n(rst_n), .pin(t1_pin), .level(t1_lvl), .fall(t1_fall));
  timer_unit_pin_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_int0 (
    .clk(clk), .rst_n(rst_n), .pin(int0_n), .level(int0_lvl), .fall(int0_fall));
  timer_unit_pin_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_int1 (
    .clk(clk), .rst_n(rst_n), .pin(int1_n), .level(int1_lvl), .fall(int1_fall));

  assign cfg0    = tmod_nib_t'(tmod_q[3:0]);
  assign cfg1    = tmod_nib_t'(tmod_q[7:4]);
  assign wr_tmod = bus.sfr_wr & (bus.sfr_addr == SFR_TMOD);
  assign wr_tcon = bus.sfr_wr & (bus.sfr_addr == SFR_TCON);
  assign wr_tl0  = bus.sfr_wr & (bus.sfr_addr == SFR_TL0);
  assign wr_th0  = bus.sfr_wr & (bus.sfr_addr == SFR_TH0);
  assign wr_tl1  = bus.sfr_wr & (bus.sfr_addr == SFR_TL1);
  assign wr_th1  = bus.sfr_wr & (bus.sfr_addr == SFR_TH1);

  // Counter-mode edges are held until the next tick so at most one counts per machine cycle
  assign run0  = tcon_q[TCON_TR0] & (~cfg0.gate | int0_lvl);
  assign run1  = tcon_q[TCON_TR1] & (~cfg1.gate | int1_lvl);
  assign ev0   = tick & run0 & (cfg0.ct ? (pend0_q | t0_fall) : 1'b1);
  assign ev1   = tick & run1 & (cfg1.ct ? (pend1_q | t1_fall) : 1'b1);
  assign ev_h0 = tick & tcon_q[TCON_TR1];
  assign inc0  = tmr_inc(cfg0.mode, tl0_q, th0_q);
  assign inc1  = tmr_inc(cfg1.mode, tl1_q, th1_q);

  // Timer, flag and register next-state arbitration
  always_comb begin
    tmod_d   = wr_tmod ? bus.sfr_wdata : tmod_q;
    tl0_d    = tl0_q;
    th0_d    = th0_q;
    tl1_d    = tl1_q;
    th1_d    = th1_q;
    ovf0     = 1'b0;
    ovf1     = 1'b0;
    ovf_h0   = 1'b0;
    pend0_d  = tick ? 1'b0 : (pend0_q | t0_fall);
    pend1_d  = tick ? 1'b0 : (pend1_q | t1_fall);

    if (cfg0.mode == MODE_SPLIT) begin
      if (ev0 && !wr_tl0) begin
        tl0_d = inc0[7:0];
        ovf0  = inc0[16];
      end else begin
        tl0_d = tl0_q;
      end
      if (ev_h0 && !wr_th0) begin
        th0_d  = th0_q + 8'd1;
        ovf_h0 = &th0_q;
      end else begin
        th0_d = th0_q;
      end
    end else if (ev0 && !wr_tl0 && !wr_th0) begin
      {ovf0, th0_d, tl0_d} = inc0;
    end else begin
      ovf0 = 1'b0;
    end

    if ((cfg1.mode != MODE_SPLIT) && ev1 && !wr_tl1 && !wr_th1) begin
      {ovf1, th1_d, tl1_d} = inc1;
    end else begin
      ovf1 = 1'b0;
    end

    tl0_d = wr_tl0 ? bus.sfr_wdata : tl0_d;
    th0_d = wr_th0 ? bus.sfr_wdata : th0_d;
    tl1_d = wr_tl1 ? bus.sfr_wdata : tl1_d;
    th1_d = wr_th1 ? bus.sfr_wdata : th1_d;

    // With Timer0 split, TH0 owns TF1; Timer1 overflows then only reach t1_ovf
    tf1_set  = (cfg0.mode == MODE_SPLIT) ? ovf_h0 : ovf1;
    t1_ovf_d = ovf1;

    tcon_d           = tcon_q;
    tcon_d[TCON_TF1] = tf1_set | (wr_tcon ? bus.sfr_wdata[TCON_TF1] : (tcon_q[TCON_TF1] & ~ack_tf1));
    tcon_d[TCON_TR1] = wr_tcon ? bus.sfr_wdata[TCON_TR1] : tcon_q[TCON_TR1];
    tcon_d[TCON_TF0] = ovf0 | (wr_tcon ? bus.sfr_wdata[TCON_TF0] : (tcon_q[TCON_TF0] & ~ack_tf0));
    tcon_d[TCON_TR0] = wr_tcon ? bus.sfr_wdata[TCON_TR0] : tcon_q[TCON_TR0];
    tcon_d[TCON_IT1] = wr_tcon ? bus.sfr_wdata[TCON_IT1] : tcon_q[TCON_IT1];
    tcon_d[TCON_IT0] = wr_tcon ? bus.sfr_wdata[TCON_IT0] : tcon_q[TCON_IT0];
    tcon_d[TCON_IE1] = tcon_q[TCON_IT1]
                     ? (int1_fall | (wr_tcon ? bus.sfr_wdata[TCON_IE1] : (tcon_q[TCON_IE1] & ~ack_ie1)))
                     : ~int1_lvl;
    tcon_d[TCON_IE0] = tcon_q[TCON_IT0]
                     ? (int0_fall | (wr_tcon ? bus.sfr_wdata[TCON_IE0] : (tcon_q[TCON_IE0] & ~ack_ie0)))
                     : ~int0_lvl;
  end

  // SFR and status registers, one block per register
  always_ff @(posedge clk) begin
    if (!rst_n) tmod_q <= 8'h00;
    else        tmod_q <= tmod_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tcon_q <= 8'h00;
    else        tcon_q <= tcon_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tl0_q <= 8'h00;
    else        tl0_q <= tl0_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) th0_q <= 8'h00;
    else        th0_q <= th0_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tl1_q <= 8'h00;
    else        tl1_q <= tl1_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) th1_q <= 8'h00;
    else        th1_q <= th1_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1_ovf_q <= 1'b0;
      pend0_q  <= 1'b0;
      pend1_q  <= 1'b0;
    end else begin
      t1_ovf_q <= t1_ovf_d;
      pend0_q  <= pend0_d;
      pend1_q  <= pend1_d;
    end
  end

  assign bus.tmod = tmod_q;
  assign bus.tcon = tcon_q;
  assign bus.tl0  = tl0_q;
  assign bus.th0  = th0_q;
  assign bus.tl1  = tl1_q;
  assign bus.th1  = th1_q;
  assign t1_ovf   = t1_ovf_q;

endmodule
